// File: rtl/coffee_pkg.sv
// Shared state encoding for the coffee brew controller.
// Each code doubles as the externally visible phase value.
package coffee_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE  = 3'b000,
    ST_HEAT  = 3'b001,
    ST_GRIND = 3'b010,
    ST_DOSE  = 3'b100,
    ST_POUR  = 3'b110,
    ST_DONE  = 3'b111
  } state_e;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that parks at zero; zero_o flags the last cycle
// of a phase.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/coffee_brew_ctrl.sv
// Brew sequencer: one heat, then grind/dose/pour repeated per cup, then a
// single-cycle DONE. Abort cancels from any busy state.
module coffee_brew_ctrl
  import coffee_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int T_HEAT   = 10,
  parameter int T_GRIND  = 5,
  parameter int T_DOSE   = 3,
  parameter int T_POUR   = 8,
  parameter int MAX_CUPS = 4,
  localparam int CUP_W   = $clog2(MAX_CUPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CUP_W-1:0] cups,
  input  logic             abort,
  output logic             busy,
  output logic [2:0]       phase,
  output logic             heater,
  output logic             grinder,
  output logic             doser,
  output logic             pump,
  output logic [CUP_W-1:0] cups_left,
  output logic             done,
  output logic             aborted
);

  localparam longint TMAX = longint'(1) << CNT_W;

  if (T_HEAT < 1 || T_GRIND < 1 || T_DOSE < 1 || T_POUR < 1 ||
      T_HEAT > TMAX || T_GRIND > TMAX || T_DOSE > TMAX || T_POUR > TMAX) begin : g_bad_param
    $error("coffee_brew_ctrl: every phase length must be in 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LD_HEAT  = CNT_W'(T_HEAT - 1);
  localparam logic [CNT_W-1:0] LD_GRIND = CNT_W'(T_GRIND - 1);
  localparam logic [CNT_W-1:0] LD_DOSE  = CNT_W'(T_DOSE - 1);
  localparam logic [CNT_W-1:0] LD_POUR  = CNT_W'(T_POUR - 1);

  function automatic logic [CUP_W-1:0] sat_cups(input logic [CUP_W-1:0] n);
    if (int'(n) > MAX_CUPS) return CUP_W'(MAX_CUPS);
    return n;
  endfunction

  state_e           state_q, state_d;
  logic [CUP_W-1:0] cups_q, cups_d;
  logic             aborted_q, aborted_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cups_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cups_q    <= cups_d;
      aborted_q <= aborted_d;
    end
  end

  // The timer is loaded only on the edge that enters a timed phase.
  always_comb begin
    state_d   = state_q;
    cups_d    = cups_q;
    aborted_d = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort && cups != '0) begin
          state_d  = ST_HEAT;
          cups_d   = sat_cups(cups);
          tmr_load = 1'b1;
          tmr_val  = LD_HEAT;
        end
      end
      ST_HEAT: begin
        if (tmr_zero) begin
          state_d  = ST_GRIND;
          tmr_load = 1'b1;
          tmr_val  = LD_GRIND;
        end
      end
      ST_GRIND: begin
        if (tmr_zero) begin
          state_d  = ST_DOSE;
          tmr_load = 1'b1;
          tmr_val  = LD_DOSE;
        end
      end
      ST_DOSE: begin
        if (tmr_zero) begin
          state_d  = ST_POUR;
          tmr_load = 1'b1;
          tmr_val  = LD_POUR;
        end
      end
      ST_POUR: begin
        if (tmr_zero) begin
          if (cups_q > CUP_W'(1)) begin
            state_d  = ST_GRIND;
            cups_d   = cups_q - CUP_W'(1);
            tmr_load = 1'b1;
            tmr_val  = LD_GRIND;
          end else begin
            state_d = ST_DONE;
            cups_d  = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      cups_d    = '0;
      aborted_d = 1'b1;
      tmr_load  = 1'b0;
    end
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    phase     = state_q;
    heater    = (state_q == ST_HEAT);
    grinder   = (state_q == ST_GRIND);
    doser     = (state_q == ST_DOSE);
    pump      = (state_q == ST_POUR);
    done      = (state_q == ST_DONE);
    cups_left = cups_q;
    aborted   = aborted_q;
  end

endmodule

// File: tb/tb_coffee_brew_ctrl.sv
// Directed bench for coffee_brew_ctrl: default-timing instance plus an
// all-phases-one-cycle instance.
module tb_coffee_brew_ctrl;

  localparam logic [2:0] P_IDLE  = 3'b000;
  localparam logic [2:0] P_HEAT  = 3'b001;
  localparam logic [2:0] P_GRIND = 3'b010;
  localparam logic [2:0] P_DOSE  = 3'b100;
  localparam logic [2:0] P_POUR  = 3'b110;
  localparam logic [2:0] P_DONE  = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, abort = 1'b0;
  logic [2:0] cups = '0;
  logic       busy, heater, grinder, doser, pump, done, aborted;
  logic [2:0] phase, cups_left;

  logic       s_start = 1'b0, s_abort = 1'b0;
  logic [2:0] s_cups = '0;
  logic       s_busy, s_heater, s_grinder, s_doser, s_pump, s_done, s_aborted;
  logic [2:0] s_phase, s_cups_left;

  coffee_brew_ctrl #(
    .CNT_W(8), .T_HEAT(10), .T_GRIND(5), .T_DOSE(3), .T_POUR(8), .MAX_CUPS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cups(cups), .abort(abort),
    .busy(busy), .phase(phase), .heater(heater), .grinder(grinder),
    .doser(doser), .pump(pump), .cups_left(cups_left), .done(done),
    .aborted(aborted)
  );

  coffee_brew_ctrl #(
    .CNT_W(1), .T_HEAT(1), .T_GRIND(1), .T_DOSE(1), .T_POUR(1), .MAX_CUPS(4)
  ) dut_fast (
    .clk(clk), .rst_n(rst_n), .start(s_start), .cups(s_cups), .abort(s_abort),
    .busy(s_busy), .phase(s_phase), .heater(s_heater), .grinder(s_grinder),
    .doser(s_doser), .pump(s_pump), .cups_left(s_cups_left), .done(s_done),
    .aborted(s_aborted)
  );

  int checks = 0;
  int failures = 0;

  // Output word: {busy, phase[2:0], heater, grinder, doser, pump, cups_left[2:0], done, aborted}
  function automatic logic [12:0] exp_word(input logic [2:0] ph, input logic [2:0] left,
                                           input logic abt);
    return {ph != P_IDLE, ph, ph == P_HEAT, ph == P_GRIND, ph == P_DOSE, ph == P_POUR,
            left, ph == P_DONE, abt};
  endfunction

  function automatic logic [12:0] act_main();
    return {busy, phase, heater, grinder, doser, pump, cups_left, done, aborted};
  endfunction

  function automatic logic [12:0] act_fast();
    return {s_busy, s_phase, s_heater, s_grinder, s_doser, s_pump, s_cups_left, s_done, s_aborted};
  endfunction

  // cups_left is not compared during the DONE cycle
  function automatic logic [12:0] mask_for(input logic [2:0] ph);
    return (ph == P_DONE) ? 13'h1FE3 : 13'h1FFF;
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp,
                     input logic [12:0] mask);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      failures++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, act, exp, mask);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected phase / cups_left for an n-cup order started in cycle 0 (default timing)
  function automatic logic [2:0] exp_ph(input int c, input int n);
    int k, r;
    if (c >= 1 && c <= 10) return P_HEAT;
    k = c - 11;
    if (k >= 0 && k < 16 * n) begin
      r = k % 16;
      if (r < 5) return P_GRIND;
      if (r < 8) return P_DOSE;
      return P_POUR;
    end
    if (k == 16 * n) return P_DONE;
    return P_IDLE;
  endfunction

  function automatic logic [2:0] exp_left(input int c, input int n);
    int k;
    if (c >= 1 && c <= 10) return 3'(n);
    k = c - 11;
    if (k >= 0 && k < 16 * n) return 3'(n - k / 16);
    return 3'd0;
  endfunction

  task automatic run_order(input int n, input int abort_cyc, input int ncyc, input string tag);
    int dones;
    logic [2:0] ph;
    logic [2:0] lf;
    logic abt;
    dones = 0;
    start = 1'b1; cups = 3'(n);
    tick();
    start = 1'b0; cups = '0;
    for (int c = 1; c <= ncyc; c++) begin
      if (abort_cyc > 0 && c > abort_cyc) begin
        ph = P_IDLE; lf = 3'd0; abt = (c == abort_cyc + 1);
      end else begin
        ph = exp_ph(c, n); lf = exp_left(c, n); abt = 1'b0;
      end
      chk($sformatf("%s_c%0d", tag, c), act_main(), exp_word(ph, lf, abt), mask_for(ph));
      if (done) dones++;
      abort = (c == abort_cyc);
      tick();
    end
    abort = 1'b0;
    checks++;
    if (dones != ((abort_cyc > 0) ? 0 : 1)) begin
      failures++;
      $display("FAIL %s_done_count: got %0d expected %0d", tag, dones, (abort_cyc > 0) ? 0 : 1);
    end
  endtask

  typedef struct {
    logic       start;
    logic [2:0] cups;
    logic       abort;
    logic [2:0] ph;
    logic [2:0] left;
    logic       abt;
  } vec_t;

  vec_t vt[10];

  logic [2:0] f_ph[10];
  logic [2:0] f_left[10];

  initial begin
    vt[0] = '{1'b1, 3'd0, 1'b0, P_IDLE, 3'd0, 1'b0};  // cups=0 ignored
    vt[1] = '{1'b0, 3'd0, 1'b1, P_IDLE, 3'd0, 1'b0};  // abort in IDLE
    vt[2] = '{1'b1, 3'd2, 1'b1, P_IDLE, 3'd0, 1'b0};  // start+abort ignored
    vt[3] = '{1'b1, 3'd7, 1'b0, P_HEAT, 3'd4, 1'b0};  // saturate to MAX_CUPS
    vt[4] = '{1'b1, 3'd1, 1'b0, P_HEAT, 3'd4, 1'b0};  // start while busy
    vt[5] = '{1'b0, 3'd0, 1'b0, P_HEAT, 3'd4, 1'b0};
    vt[6] = '{1'b0, 3'd0, 1'b1, P_IDLE, 3'd0, 1'b1};  // abort in HEAT
    vt[7] = '{1'b0, 3'd0, 1'b0, P_IDLE, 3'd0, 1'b0};
    vt[8] = '{1'b1, 3'd2, 1'b0, P_HEAT, 3'd2, 1'b0};
    vt[9] = '{1'b0, 3'd0, 1'b1, P_IDLE, 3'd0, 1'b1};

    f_ph   = '{P_HEAT, P_GRIND, P_DOSE, P_POUR, P_GRIND, P_DOSE, P_POUR, P_DONE, P_IDLE, P_IDLE};
    f_left = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};

    rst_n = 1'b0;
    tick(); tick();
    chk("reset_main", act_main(), 13'h0000, 13'h1FFF);
    chk("reset_fast", act_fast(), 13'h0000, 13'h1FFF);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      start = vt[i].start; cups = vt[i].cups; abort = vt[i].abort;
      tick();
      chk($sformatf("vec%0d", i), act_main(), exp_word(vt[i].ph, vt[i].left, vt[i].abt), 13'h1FFF);
    end
    start = 1'b0; cups = '0; abort = 1'b0;
    tick();

    run_order(1, 0, 30, "one_cup");
    run_order(3, 0, 62, "three_cup");
    run_order(3, 37, 60, "abort_pour2");

    // Reset mid-GRIND
    start = 1'b1; cups = 3'd2;
    tick();
    start = 1'b0; cups = '0;
    for (int i = 0; i < 11; i++) tick();
    chk("pre_reset_grind", act_main(), exp_word(P_GRIND, 3'd2, 1'b0), 13'h1FFF);
    rst_n = 1'b0;
    #1;
    chk("async_reset", act_main(), 13'h0000, 13'h1FFF);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("post_reset_c%0d", i), act_main(), 13'h0000, 13'h1FFF);
    end

    // All phases one cycle long
    s_start = 1'b1; s_cups = 3'd2;
    tick();
    s_start = 1'b0; s_cups = '0;
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("fast_c%0d", c), act_fast(), exp_word(f_ph[c-1], f_left[c-1], 1'b0),
          mask_for(f_ph[c-1]));
      s_start = (c == 2 || c == 5); s_cups = (c == 2 || c == 5) ? 3'd4 : 3'd0;
      tick();
    end
    s_start = 1'b0; s_cups = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coffee_brew_ctrl.md
COFFEE_BREW_CTRL -- requirements
Module: coffee_brew_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of phase timer.
REQ-002 SHALL have parameter T_HEAT, default 10: heat phase length in cycles.
REQ-003 SHALL have parameter T_GRIND, default 5: grind phase length in cycles.
REQ-004 SHALL have parameter T_DOSE, default 3: dose phase length in cycles.
REQ-005 SHALL have parameter T_POUR, default 8: pour phase length in cycles.
REQ-006 SHALL have parameter MAX_CUPS, default 4: largest cup count per order; CUP_W = clog2(MAX_CUPS+1).
REQ-007 SHALL have port clk, input, 1: single clock; all state changes occur on the rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port start, input, 1: one-cycle order request.
REQ-010 SHALL have port cups, input, CUP_W: cup count, sampled together with start.
REQ-011 SHALL have port abort, input, 1: level-sensitive cancel.
REQ-012 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-013 SHALL have port phase, output, 3: current state code.
REQ-014 SHALL have ports heater, grinder, doser and pump, each output, 1: actuator enables, high only in HEAT, GRIND, DOSE and POUR respectively.
REQ-015 SHALL have port cups_left, output, CUP_W: cups remaining, including the current cup.
REQ-016 SHALL have port done, output, 1: one-cycle pulse when an order completes.
REQ-017 SHALL have port aborted, output, 1: one-cycle pulse when an order is cancelled.

Function
REQ-018 SHALL implement states IDLE=000, HEAT=001, GRIND=010, DOSE=100, POUR=110, DONE=111; phase SHALL equal the state code.
REQ-019 In IDLE, start=1 with cups!=0 SHALL go to HEAT next cycle and latch cups_left=min(cups, MAX_CUPS).
REQ-020 In IDLE, start=1 with cups=0 SHALL be ignored; start in any other state SHALL be ignored (no queueing).
REQ-021 Each timed phase SHALL last exactly its T_* cycles: timer loads T-1 on entry and the state advances in the cycle after the timer reads 0.
REQ-022 Transitions SHALL be HEAT->GRIND->DOSE->POUR; at the end of POUR, cups_left>1 SHALL decrement cups_left and go to GRIND (no reheat), and cups_left==1 SHALL go to DONE.
REQ-023 DONE SHALL last one cycle, assert done, set cups_left=0 and return to IDLE.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, zero all actuators and cups_left, and pulse aborted for one cycle; abort has priority over phase expiry and done.
REQ-025 abort in IDLE SHALL have no effect; start and abort together in IDLE SHALL be ignored.
REQ-026 Actuator outputs SHALL be registered or decoded from the state only, with no combinational path from inputs.
REQ-027 Parameters SHALL satisfy 1 <= T_* <= 2^CNT_W; elaboration SHALL fail otherwise.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, timer=0, cups_left=0, and busy, done, aborted and all actuators to 0, including mid-order; the order SHALL NOT resume after reset is released.

Structure
REQ-029 State codes and the state typedef SHALL reside in shared package coffee_pkg.
REQ-030 The down-counter with load and zero flag SHALL be sub-module phase_timer (parameter CNT_W).

Verification
REQ-031 Order with cups=1, defaults: start at cycle 0 -> HEAT cycles 1-10, GRIND 11-15, DOSE 16-18, POUR 19-26, done=1 at cycle 27, then IDLE.
REQ-032 Order with cups=3 -> single HEAT, three GRIND/DOSE/POUR loops, cups_left 3->2->1, one done pulse after 10+3*16 cycles.
REQ-033 Out-of-range and ignored requests: start with cups=0 -> no activity; cups=7 with MAX_CUPS=4 -> cups_left=4.
REQ-034 Abort during the 2nd POUR -> IDLE next cycle, pump=0, aborted pulse, no done pulse.
REQ-035 rst_n low during GRIND -> all outputs 0 immediately; after release, stays in IDLE until a new start.
REQ-036 Parameter sweep with all T_*=1 and CNT_W=1 -> each phase lasts 1 cycle; start while busy has no effect.
